// File: rtl/regfile.sv
// regfile: architectural register file at the write-back end of the
// execute stage. It takes one write per cycle from exu, gives two
// combinational source-operand reads to decode, and gives one combinational
// debug read. It also counts committed write-back cycles.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset; clears every register and wb_cnt
//   e_regW     write enable from the execute stage
//   e_regAddr  destination index (a write to index 0 is discarded)
//   e_regData  write-back data, stored unmodified
//   rs1_addr   source 1 index       rs1_data  source 1 value
//   rs2_addr   source 2 index       rs2_data  source 2 value
//   dbg_addr   debug read index     dbg_data  debug read value
//   wb_cnt     number of cycles with e_regW=1 since reset, wraps silently
module regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  e_regW,
  input  logic [ADDR_WIDTH-1:0] e_regAddr,
  input  logic [DATA_WIDTH-1:0] e_regData,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [CNT_WIDTH-1:0]  wb_cnt
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regArray [NumRegs];
  logic [CNT_WIDTH-1:0]  wbCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regArray[i] <= '0;
      end
    end else if (e_regW && (e_regAddr != '0)) begin
      regArray[e_regAddr] <= e_regData;
    end
  end

  // Every enabled cycle counts, including the discarded writes to x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbCnt <= '0;
    end else if (e_regW) begin
      wbCnt <= wbCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Reads show stored state only. There is no bypass from the write port,
  // because a bypass would close the loop rs -> alu -> e_regData -> rs in the
  // single-cycle datapath. Index 0 is forced to zero at the read side.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regArray[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regArray[rs2_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regArray[dbg_addr];
  end

  assign wb_cnt = wbCnt;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic        e_regW;
  logic [4:0]  e_regAddr;
  logic [31:0] e_regData;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [63:0] wb_cnt;

  regfile dut (
    .clk(clk), .rst_n(rst_n),
    .e_regW(e_regW), .e_regAddr(e_regAddr), .e_regData(e_regData),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_cnt(wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] d;
    logic [63:0] c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int phase = 0;

  // Reference model: the architectural view of the register file.
  logic [31:0] mdl [32];
  logic [63:0] mdlCnt;

  function automatic logic [31:0] mdlRead(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mdl[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdlCnt = 64'd0;
  endtask

  task automatic pushExp(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    exp_t e;
    e.phase = phase;
    e.r1 = mdlRead(a1);
    e.r2 = mdlRead(a2);
    e.d  = mdlRead(ad);
    e.c  = mdlCnt;
    q.push_back(e);
  endtask

  // One clock cycle. The task is entered just after a rising edge. The
  // expected values are pushed before the edge, so they show the state
  // before any write in this cycle.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                      input bit chk);
    e_regW = w; e_regAddr = wa; e_regData = wd;
    rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    if (chk) pushExp(a1, a2, ad);
    @(posedge clk);
    if (rst_n && w) begin
      mdlCnt = mdlCnt + 64'd1;
      if (wa != 5'd0) mdl[wa] = wd;
    end
    #1;
  endtask

  // Monitor: at each falling edge, pop one pending expectation and compare.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (rs1_data !== e.r1) begin
        failures++;
        $display("FAIL rs1 phase=%0d got=%h exp=%h", e.phase, rs1_data, e.r1);
      end
      checks++;
      if (rs2_data !== e.r2) begin
        failures++;
        $display("FAIL rs2 phase=%0d got=%h exp=%h", e.phase, rs2_data, e.r2);
      end
      checks++;
      if (dbg_data !== e.d) begin
        failures++;
        $display("FAIL dbg phase=%0d got=%h exp=%h", e.phase, dbg_data, e.d);
      end
      checks++;
      if (wb_cnt !== e.c) begin
        failures++;
        $display("FAIL wb_cnt phase=%0d got=%0d exp=%0d", e.phase, wb_cnt, e.c);
      end
    end
  end

  initial begin
    clearModel();
    rst_n = 1'b0;
    e_regW = 1'b0; e_regAddr = '0; e_regData = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5, 1);

    // Basic write: reads show the old value before the edge and the new value after it.
    phase = 2;
    step(1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 1);
    step(0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 1);

    // x0 hardwire: the write is discarded but still counted.
    phase = 3;
    step(1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1);
    step(0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1);

    // Back-to-back writes, then a disabled cycle with junk address/data.
    phase = 4;
    step(1, 5'd1, 32'd1, 5'd1, 5'd1, 5'd1, 1);
    step(1, 5'd1, 32'd2, 5'd1, 5'd1, 5'd1, 1);
    step(0, 5'd1, 32'h55, 5'd1, 5'd1, 5'd1, 1);
    step(0, 5'd0, 32'd0, 5'd1, 5'd1, 5'd1, 1);

    // Fill x1..x31 and read them on all three ports.
    phase = 5;
    for (int i = 1; i < 32; i++) step(1, 5'(i), 32'h100 + i, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 32; i++) step(0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i), 1);
    step(0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7, 1);

    // Async reset pulse between edges: outputs are zero at once, for every index.
    phase = 1;
    rst_n = 1'b0;
    clearModel();
    for (int i = 0; i < 32; i++) step(0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i), 1);
    rst_n = 1'b1;
    step(0, 5'd0, 32'd0, 5'd9, 5'd31, 5'd1, 1);

    // Reset asserted during a write cycle: the write is discarded.
    phase = 6;
    step(1, 5'd3, 32'h77, 5'd0, 5'd0, 5'd0, 0);
    e_regW = 1'b1; e_regAddr = 5'd3; e_regData = 32'h1234;
    #3;
    rst_n = 1'b0;
    clearModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3, 1);

    // Random traffic.
    phase = 7;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           5'($urandom), 5'($urandom), 5'($urandom), 1);
    end
    e_regW = 1'b0;

    // Wait a bounded time for the monitor to empty the queue.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
